datapath: RTL and testbench



---
 rtl/datapath_pkg.sv | 28 ++
 rtl/datapath_regfile.sv | 34 +++
 rtl/datapath.sv | 114 +++++++++++
 tb/tb_datapath.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, instruction field positions and ALU opcodes
// for the single-cycle execution datapath.
package datapath_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Replicate the immediate's sign bit into the upper half-word
  function automatic logic [DATA_W-1:0] sign_extend(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_regfile.sv
// regfile: 32 x 32-bit register file, two combinational read ports and one
// synchronous write port. R0 is only ever loaded by the clear, so it always
// reads zero. rst is an asynchronous active-low clear of every register.
module regfile
  import datapath_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ra_addr,
  input  logic [REG_ADDR_W-1:0] rb_addr,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     ra_data,
  output logic [DATA_W-1:0]     rb_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Clear everything on reset; otherwise commit the write-back, never to R0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/datapath.sv
// datapath: single-cycle MIPS-style execution stage (register file, sign
// extender, ALU, data memory, write-back mux) driven by decoded control.
// Optional feature: define DATAPATH_OVF_EN to add the Overflow output.
module datapath
  import datapath_pkg::*;
#(
  parameter int DMEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Instructions,
  input  logic              RegDst,
  input  logic              RegWr,
  input  logic              ALUsrc,
  input  logic [1:0]        ALUcntrl,
  input  logic              MemWr,
  input  logic              MemToReg,
  output logic [DATA_W-1:0] seOut,
  output logic [DATA_W-1:0] reg_Da,
  output logic              Zero
`ifdef DATAPATH_OVF_EN
  ,
  output logic              Overflow
`endif
);

  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [15:0]           imm;
  logic                  unused_opcode;

  logic [DATA_W-1:0]     reg_Db;
  logic [DATA_W-1:0]     alu_b;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]     wb_data;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DMEM_AW-1:0]    dmem_index;

  logic [DATA_W-1:0]     dmem [DMEM_WORDS];

  assign rs  = Instructions[RS_MSB:RS_LSB];
  assign rt  = Instructions[RT_MSB:RT_LSB];
  assign rd  = Instructions[RD_MSB:RD_LSB];
  assign imm = Instructions[IMM_MSB:IMM_LSB];

  // The opcode field is decoded upstream by the control unit
  assign unused_opcode = ^Instructions[31:26];

  assign seOut = sign_extend(imm);
  assign alu_b = ALUsrc ? seOut : reg_Db;

  // ALU: 32-bit two's complement, carry-out dropped
  always_comb begin
    alu_result = '0;
    case (ALUcntrl)
      ALU_ADD: alu_result = reg_Da + alu_b;
      ALU_SUB: alu_result = reg_Da - alu_b;
      ALU_AND: alu_result = reg_Da & alu_b;
      ALU_OR:  alu_result = reg_Da | alu_b;
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

`ifdef DATAPATH_OVF_EN
  // Signed overflow: operands' effective signs agree but the result sign differs
  always_comb begin
    Overflow = 1'b0;
    case (ALUcntrl)
      ALU_ADD: Overflow = (reg_Da[DATA_W-1] == alu_b[DATA_W-1]) &&
                          (alu_result[DATA_W-1] != reg_Da[DATA_W-1]);
      ALU_SUB: Overflow = (reg_Da[DATA_W-1] != alu_b[DATA_W-1]) &&
                          (alu_result[DATA_W-1] != reg_Da[DATA_W-1]);
      default: Overflow = 1'b0;
    endcase
  end
`endif

  // Word index from the byte address; upper bits dropped so addresses wrap
  assign dmem_index = alu_result[DMEM_AW+1:2];
  assign mem_rdata  = dmem[dmem_index];

  // Data memory: cleared by reset, stores the rt value on a store cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= '0;
      end
    end else if (MemWr) begin
      dmem[dmem_index] <= reg_Db;
    end
  end

  assign wb_data = MemToReg ? mem_rdata : alu_result;
  assign wb_addr = RegDst ? rd : rt;

  regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rs),
    .rb_addr (rt),
    .wr_addr (wb_addr),
    .wr_en   (RegWr),
    .wr_data (wb_data),
    .ra_data (reg_Da),
    .rb_data (reg_Db)
  );

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed-vector bench for the single-cycle datapath. Stimulus
// pushes the expected observation into a scoreboard queue; a monitor pops and
// compares on the falling edge of every cycle flagged as observed.
module tb_datapath;

  localparam int K_DA   = 0;
  localparam int K_SE   = 1;
  localparam int K_ZERO = 2;
  localparam int K_OVF  = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } check_t;

  logic        clk;
  logic        rst;
  logic [31:0] instructions;
  logic        reg_dst;
  logic        reg_wr;
  logic        alu_src;
  logic [1:0]  alu_cntrl;
  logic        mem_wr;
  logic        mem_to_reg;
  logic [31:0] se_out;
  logic [31:0] reg_da;
  logic        zero;
  logic        overflow;

  logic        obs_valid;
  check_t      sb_q[$];
  int          checks;
  int          errors;

  datapath #(.DMEM_WORDS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .Instructions (instructions),
    .RegDst       (reg_dst),
    .RegWr        (reg_wr),
    .ALUsrc       (alu_src),
    .ALUcntrl     (alu_cntrl),
    .MemWr        (mem_wr),
    .MemToReg     (mem_to_reg),
    .seOut        (se_out),
    .reg_Da       (reg_da),
    .Zero         (zero)
`ifdef DATAPATH_OVF_EN
    ,
    .Overflow     (overflow)
`endif
  );

`ifndef DATAPATH_OVF_EN
  assign overflow = 1'b0;
`endif

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk_i(input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] rs5;
    logic [4:0] rt5;
    rs5 = rs[4:0];
    rt5 = rt[4:0];
    return {6'b0, rs5, rt5, imm};
  endfunction

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
    logic [4:0] rs5;
    logic [4:0] rt5;
    logic [4:0] rd5;
    rs5 = rs[4:0];
    rt5 = rt[4:0];
    rd5 = rd[4:0];
    return {6'b0, rs5, rt5, rd5, 11'b0};
  endfunction

  // Drive one full cycle; called at posedge+1 and returns at the next posedge+1
  task automatic applyStimulus(input logic [31:0] instr, input logic dst, input logic wr,
                               input logic src, input logic [1:0] op, input logic mwr,
                               input logic m2r, input bit obs, input int kind,
                               input logic [31:0] exp, input string name);
    check_t item;
    instructions = instr;
    reg_dst      = dst;
    reg_wr       = wr;
    alu_src      = src;
    alu_cntrl    = op;
    mem_wr       = mwr;
    mem_to_reg   = m2r;
    if (obs) begin
      item.name = name;
      item.kind = kind;
      item.exp  = exp;
      sb_q.push_back(item);
    end
    obs_valid = obs;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  // Idle cycle that reads register r through port A and checks it
  task automatic readReg(input int r, input logic [31:0] exp, input string name);
    applyStimulus(mk_i(r, 0, 16'h0), 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0,
                  1'b1, K_DA, exp, name);
  endtask

  task automatic checkOutput(input check_t item);
    logic [31:0] act;
    case (item.kind)
      K_DA:    act = reg_da;
      K_SE:    act = se_out;
      K_ZERO:  act = {31'b0, zero};
      default: act = {31'b0, overflow};
    endcase
    checks++;
    if (act !== item.exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", item.name, act, item.exp);
    end
  endtask

  // Monitor: every observed cycle must have a queued expectation
  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_underflow: got observation, expected queued entry");
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  initial begin
    check_t item;
    checks       = 0;
    errors       = 0;
    obs_valid    = 1'b0;
    rst          = 1'b0;
    instructions = '0;
    reg_dst      = 1'b0;
    reg_wr       = 1'b0;
    alu_src      = 1'b0;
    alu_cntrl    = OP_ADD;
    mem_wr       = 1'b0;
    mem_to_reg   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, still in reset
    readReg(1, 32'h0, "reset_R1");
    rst = 1'b1;

    // addi $1,$0,2015 ; check the immediate path in the same cycle
    applyStimulus(mk_i(0, 1, 16'd2015), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0,
                  1'b1, K_SE, 32'h0000_07DF, "seOut_2015");
    readReg(1, 32'h0000_07DF, "addi_R1");

    // addi $2,$0,404 ; add $1,$1,$2 (old R1 visible during the write cycle)
    applyStimulus(mk_i(0, 2, 16'd404), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_r(1, 2, 1), 1'b1, 1'b1, 1'b0, OP_ADD, 1'b0, 1'b0,
                  1'b1, K_DA, 32'd2015, "no_bypass_R1");
    readReg(1, 32'd2419, "add_R1");
`ifdef DATAPATH_OVF_EN
    applyStimulus(mk_r(1, 2, 0), 1'b1, 1'b0, 1'b0, OP_ADD, 1'b0, 1'b0,
                  1'b1, K_OVF, 32'h0, "no_overflow_add");
`endif

    // sw $0,4($0) with don't-care controls ; lw $3,0($0)
    applyStimulus(mk_i(0, 0, 16'd4), 1'bx, 1'b0, 1'b1, OP_ADD, 1'b1, 1'bx,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_i(0, 3, 16'd0), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1,
                  1'b1, K_ZERO, 32'h1, "lw_addr_zero");
    readReg(3, 32'h0, "lw_R3");
    readReg(1, 32'd2419, "sw_keeps_R1");
    readReg(2, 32'd404, "sw_keeps_R2");

    // sw $1,8($0) ; lw $6,8($0) ; lw $7,264($0) wraps to the same word
    applyStimulus(mk_i(0, 1, 16'd8), 1'bx, 1'b0, 1'b1, OP_ADD, 1'b1, 1'bx,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_i(0, 6, 16'd8), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_i(0, 7, 16'd264), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1,
                  1'b0, K_DA, 32'h0, "");
    readReg(6, 32'd2419, "lw_R6");
    readReg(7, 32'd2419, "lw_wrap_R7");

    // add $5,$1,$0
    applyStimulus(mk_r(1, 0, 5), 1'b1, 1'b1, 1'b0, OP_ADD, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    readReg(5, 32'd2419, "add_R5");

    // Negative immediate ; addi $4,$0,-1
    applyStimulus(mk_i(0, 4, 16'hFFFF), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0,
                  1'b1, K_SE, 32'hFFFF_FFFF, "seOut_neg");
    readReg(4, 32'hFFFF_FFFF, "addi_R4");

    // Zero flag both ways
    applyStimulus(mk_r(1, 1, 0), 1'b1, 1'b0, 1'b0, OP_SUB, 1'b0, 1'b0,
                  1'b1, K_ZERO, 32'h1, "sub_equal_zero");
    applyStimulus(mk_r(1, 2, 0), 1'b1, 1'b0, 1'b0, OP_SUB, 1'b0, 1'b0,
                  1'b1, K_ZERO, 32'h0, "sub_diff_zero");

    // and $8,$1,$2 ; or $9,$1,$2
    applyStimulus(mk_r(1, 2, 8), 1'b1, 1'b1, 1'b0, OP_AND, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_r(1, 2, 9), 1'b1, 1'b1, 1'b0, OP_OR, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    readReg(8, 32'h0000_0110, "and_R8");
    readReg(9, 32'h0000_09F7, "or_R9");

    // Write to R0 is discarded
    applyStimulus(mk_i(0, 0, 16'd5), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    readReg(0, 32'h0, "R0_stays_zero");

    // Register and memory write together: R1 <= 12, mem[3] <= old R1
    applyStimulus(mk_i(0, 1, 16'd12), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b1, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    applyStimulus(mk_i(0, 11, 16'd12), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1,
                  1'b0, K_DA, 32'h0, "");
    readReg(11, 32'd2419, "dual_write_mem");
    readReg(1, 32'd12, "dual_write_R1");

    // Reset asserted mid-cycle clears R1 immediately
    item.name = "midcycle_reset_R1";
    item.kind = K_DA;
    item.exp  = 32'h0;
    sb_q.push_back(item);
    instructions = mk_i(1, 0, 16'h0);
    reg_wr       = 1'b0;
    mem_wr       = 1'b0;
    obs_valid    = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;

    // An edge with RegWr=1 during reset writes nothing
    applyStimulus(mk_i(0, 1, 16'd7), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b0,
                  1'b0, K_DA, 32'h0, "");
    rst = 1'b1;
    readReg(1, 32'h0, "reset_blocks_write");

    // Data memory was cleared as well
    applyStimulus(mk_i(0, 12, 16'd8), 1'b0, 1'b1, 1'b1, OP_ADD, 1'b0, 1'b1,
                  1'b0, K_DA, 32'h0, "");
    readReg(12, 32'h0, "reset_clears_mem");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
